scan_mux: RTL and testbench

Parametrised, registered N-channel multiplexer with a manual-select mode and an auto-scan mode. Auto-scan steps through every channel, holding each for a programmable number of cycles. The block is the clocked successor to the 16-to-1 combinational multiplexer. It sits between a bank of input channels and a single downstream consumer, such as a display or serial port, that needs each channel presented in turn with a tag and a frame marker.

---
 rtl/scan_mux_if.sv | 28 ++
 rtl/scan_mux.sv | 140 ++++++++++++++
 tb/tb_scan_mux.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_if.sv
// Channel bank / consumer bundle for scan_mux.
// The master side drives enable, mode, select and channel data; the slave side
// (the multiplexer) returns the registered sample, its tag and the markers.
interface scan_mux_if #(
  parameter int CH = 16,
  parameter int W  = 1
);
  localparam int SEL_W = $clog2(CH);

  logic              E_N;
  logic              MODE;
  logic [SEL_W-1:0]  S;
  logic [CH*W-1:0]   D;
  logic [W-1:0]      Y;
  logic [SEL_W-1:0]  CH_OUT;
  logic              VALID;
  logic              WRAP;

  modport master (
    output E_N, MODE, S, D,
    input  Y, CH_OUT, VALID, WRAP
  );

  modport slave (
    input  E_N, MODE, S, D,
    output Y, CH_OUT, VALID, WRAP
  );
endinterface

// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select and auto-scan.
// Auto-scan holds each channel for DWELL cycles and flags the final sample of
// the last channel with WRAP. All outputs are registered (1-cycle latency).
module scan_mux #(
  parameter  int CH    = 16,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input logic       CLK,
  input logic       RST_N,
  scan_mux_if.slave bus
);

  localparam int                DCNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(CH - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    OP_OFF,
    OP_MANUAL,
    OP_AUTO
  } op_e;

  op_e               op;
  logic [W-1:0]      chan [CH];
  logic [W-1:0]      s_data;
  logic [W-1:0]      a_data;
  logic              s_legal;

  logic [SEL_W-1:0]  ch_q,     ch_d;
  logic [DCNT_W-1:0] dcnt_q,   dcnt_d;
  logic [W-1:0]      y_q,      y_d;
  logic [SEL_W-1:0]  ch_out_q, ch_out_d;
  logic              valid_q,  valid_d;
  logic              wrap_q,   wrap_d;

  // Decode the operating mode from enable and mode inputs.
  always_comb begin
    if (bus.E_N)
      op = OP_OFF;
    else if (bus.MODE)
      op = OP_AUTO;
    else
      op = OP_MANUAL;
  end

  // Unpack the channel bank into one entry per channel.
  always_comb begin
    for (int unsigned k = 0; k < CH; k++)
      chan[k] = bus.D[k*W +: W];
  end

  // Select data for the manual select and the scan channel; a select value
  // with no matching channel (CH not a power of two) is flagged illegal.
  always_comb begin
    s_data  = '0;
    a_data  = '0;
    s_legal = 1'b0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (bus.S == SEL_W'(k)) begin
        s_data  = chan[k];
        s_legal = 1'b1;
      end
      if (ch_q == SEL_W'(k))
        a_data = chan[k];
    end
  end

  // Next-state and next-output logic for all three modes.
  always_comb begin
    ch_d     = ch_q;
    dcnt_d   = dcnt_q;
    y_d      = '0;
    ch_out_d = ch_out_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    unique case (op)
      OP_OFF: begin
        // Outputs blanked; scan position and tag are kept for resumption.
      end
      OP_MANUAL: begin
        // Loading ch and clearing dcnt every cycle makes a later switch to
        // auto start at the selected channel with a full dwell.
        ch_out_d = bus.S;
        dcnt_d   = '0;
        if (s_legal) begin
          y_d     = s_data;
          valid_d = 1'b1;
          ch_d    = bus.S;
        end else begin
          ch_d    = '0;
        end
      end
      OP_AUTO: begin
        y_d      = a_data;
        ch_out_d = ch_q;
        valid_d  = 1'b1;
        if (dcnt_q == DCNT_LAST) begin
          dcnt_d = '0;
          if (ch_q == CH_LAST) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d   = ch_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ch_q     <= '0;
      dcnt_q   <= '0;
      y_q      <= '0;
      ch_out_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      dcnt_q   <= dcnt_d;
      y_q      <= y_d;
      ch_out_q <= ch_out_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.Y      = y_q;
  assign bus.CH_OUT = ch_out_q;
  assign bus.VALID  = valid_q;
  assign bus.WRAP   = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: a 16-channel, dwell-4, 1-bit instance and a
// 12-channel, dwell-1, 4-bit instance. Expected outputs are queued when each
// cycle's stimulus is driven and compared after the following rising edge.
module tb_scan_mux;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst16;
  logic rst12;

  scan_mux_if #(.CH(16), .W(1)) bus16 ();
  scan_mux_if #(.CH(12), .W(4)) bus12 ();

  scan_mux #(.CH(16), .W(1), .DWELL(4)) u16 (
    .CLK   (CLK),
    .RST_N (rst16),
    .bus   (bus16.slave)
  );

  scan_mux #(.CH(12), .W(4), .DWELL(1)) u12 (
    .CLK   (CLK),
    .RST_N (rst12),
    .bus   (bus12.slave)
  );

  typedef struct {
    string nm;
    int    y;
    int    ch;
    int    valid;
    int    wrap;
  } exp_t;

  typedef struct {
    logic [3:0] s;
    int         y;
  } vec_t;

  exp_t q16[$];
  exp_t q12[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step16(input logic rst_n, input logic e_n, input logic mode,
                        input logic [3:0] s, input logic [15:0] d, input string nm,
                        input int ey, input int ech, input int ev, input int ew);
    exp_t e;
    @(negedge CLK);
    rst16      = rst_n;
    bus16.E_N  = e_n;
    bus16.MODE = mode;
    bus16.S    = s;
    bus16.D    = d;
    e.nm = nm; e.y = ey; e.ch = ech; e.valid = ev; e.wrap = ew;
    q16.push_back(e);
    @(posedge CLK);
    #1;
    e = q16.pop_front();
    cmp({e.nm, ".y"},     32'(bus16.Y),      e.y);
    cmp({e.nm, ".ch"},    32'(bus16.CH_OUT), e.ch);
    cmp({e.nm, ".valid"}, 32'(bus16.VALID),  e.valid);
    cmp({e.nm, ".wrap"},  32'(bus16.WRAP),   e.wrap);
  endtask

  task automatic step12(input logic rst_n, input logic e_n, input logic mode,
                        input logic [3:0] s, input logic [47:0] d, input string nm,
                        input int ey, input int ech, input int ev, input int ew);
    exp_t e;
    @(negedge CLK);
    rst12      = rst_n;
    bus12.E_N  = e_n;
    bus12.MODE = mode;
    bus12.S    = s;
    bus12.D    = d;
    e.nm = nm; e.y = ey; e.ch = ech; e.valid = ev; e.wrap = ew;
    q12.push_back(e);
    @(posedge CLK);
    #1;
    e = q12.pop_front();
    cmp({e.nm, ".y"},     32'(bus12.Y),      e.y);
    cmp({e.nm, ".ch"},    32'(bus12.CH_OUT), e.ch);
    cmp({e.nm, ".valid"}, 32'(bus12.VALID),  e.valid);
    cmp({e.nm, ".wrap"},  32'(bus12.WRAP),   e.wrap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t        sweep [16];
    logic [15:0] pat;
    logic [47:0] d12;
    int          c;

    pat = 16'hA5C3;
    for (int k = 0; k < 16; k++) begin
      sweep[k].s = 4'(k);
      sweep[k].y = int'(pat[k]);
    end
    for (int k = 0; k < 12; k++)
      d12[k*4 +: 4] = 4'(k + 1);

    rst16 = 1'b0; bus16.E_N = 1'b1; bus16.MODE = 1'b0; bus16.S = '0; bus16.D = '0;
    rst12 = 1'b0; bus12.E_N = 1'b1; bus12.MODE = 1'b0; bus12.S = '0; bus12.D = '0;

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++)
      step16(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
             "rst16", 0, 0, 0, 0);

    // Manual sweep through every select value.
    for (int k = 0; k < 16; k++)
      step16(1'b1, 1'b0, 1'b0, sweep[k].s, pat, $sformatf("sweep%0d", k),
             sweep[k].y, k, 1, 0);

    // Park at channel 0, then run a full frame plus part of the next.
    step16(1'b1, 1'b0, 1'b0, 4'd0, 16'h0001, "park0", 1, 0, 1, 0);
    for (int t = 0; t < 94; t++) begin
      c = (t / 4) % 16;
      step16(1'b1, 1'b0, 1'b1, 4'($urandom), 16'h0001, $sformatf("frame%0d", t),
             (c == 0) ? 1 : 0, c, 1, (t % 64 == 63) ? 1 : 0);
    end

    // Reset in the middle of channel 7's dwell.
    step16(1'b0, 1'($urandom), 1'b1, 4'($urandom), 16'h0001, "midrst", 0, 0, 0, 0);

    // Scan restarts at channel 0 with a full dwell; stop after channel 5 dcnt 2.
    for (int t = 0; t < 23; t++) begin
      c = t / 4;
      step16(1'b1, 1'b0, 1'b1, 4'd0, 16'h0001, $sformatf("restart%0d", t),
             (c == 0) ? 1 : 0, c, 1, 0);
    end

    // Disabled for 10 cycles: outputs blanked, tag held.
    for (int i = 0; i < 10; i++)
      step16(1'b1, 1'b1, 1'b1, 4'($urandom), 16'hFFFF, $sformatf("off%0d", i),
             0, 5, 0, 0);

    // Resume: one more cycle of channel 5, then channel 6.
    for (int t = 23; t < 28; t++)
      step16(1'b1, 1'b0, 1'b1, 4'd0, 16'h0020, $sformatf("resume%0d", t),
             (t / 4 == 5) ? 1 : 0, t / 4, 1, 0);

    // Manual S=9 then auto: channel 9 for a full dwell, then 10.
    step16(1'b1, 1'b0, 1'b0, 4'd9, 16'h0200, "man9", 1, 9, 1, 0);
    for (int i = 0; i < 5; i++)
      step16(1'b1, 1'b0, 1'b1, 4'd0, 16'h0200, $sformatf("auto9_%0d", i),
             (i < 4) ? 1 : 0, (i < 4) ? 9 : 10, 1, 0);

    // Auto to manual mid-dwell takes effect at once; D is sampled every edge.
    step16(1'b1, 1'b0, 1'b0, 4'd3, 16'h0008, "man3a", 1, 3, 1, 0);
    step16(1'b1, 1'b0, 1'b0, 4'd3, 16'h0000, "man3b", 0, 3, 0 + 1, 0);

    // 12-channel instance: reset state.
    step12(1'b0, 1'b0, 1'b1, 4'd5, d12, "rst12", 0, 0, 0, 0);

    // Manual through all select codes, including the illegal 12..15.
    for (int k = 0; k < 16; k++)
      step12(1'b1, 1'b0, 1'b0, 4'(k), d12, $sformatf("m12_%0d", k),
             (k < 12) ? k + 1 : 0, k, (k < 12) ? 1 : 0, 0);

    // Auto with DWELL=1 from channel 0 (last select was illegal).
    for (int t = 0; t < 26; t++) begin
      c = t % 12;
      step12(1'b1, 1'b0, 1'b1, 4'd0, d12, $sformatf("a12_%0d", t),
             c + 1, c, 1, (c == 11) ? 1 : 0);
    end

    // Disable, then resume at the same channel.
    for (int i = 0; i < 3; i++)
      step12(1'b1, 1'b1, 1'b1, 4'd7, d12, $sformatf("off12_%0d", i), 0, 1, 0, 0);
    for (int t = 26; t < 30; t++)
      step12(1'b1, 1'b0, 1'b1, 4'd0, d12, $sformatf("res12_%0d", t),
             (t % 12) + 1, t % 12, 1, 0);

    // Illegal and highest legal manual selects.
    step12(1'b1, 1'b0, 1'b0, 4'd13, d12, "ill13", 0, 13, 0, 0);
    step12(1'b1, 1'b0, 1'b0, 4'd11, d12, "leg11", 12, 11, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
